// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit over a word-wide single-port memory.
// Sub-word stores are read-modify-write since the memory has no byte enables.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 10
`endif
module dmem_lsu (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_sign,
  input  logic [`ADDR+1:0]   req_addr,
  input  logic [`WORD-1:0]   req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [`WORD-1:0]   resp_rdata,
  output logic [`ADDR-1:0]   mem_A,
  output logic               mem_W,
  output logic [`WORD-1:0]   mem_D,
  input  logic [`WORD-1:0]   mem_Q
);
  typedef enum logic [2:0] {IDLE, RD, LD_CAP, ST_MRG, WR} state_t;
  state_t state, state_nx;
  logic we_q, sign_q, accept, bad;
  logic [1:0] size_q;
  logic [`ADDR+1:0] addr_q;
  logic [`WORD-1:0] wdata_q, shifted, lane_m, lane_d, merged, loaded;
  logic [4:0] sh;
  assign req_ready = state == IDLE;
  assign accept = req_valid & req_ready;
  assign bad = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
               (req_size == 2'b10 & |req_addr[1:0]);
  assign mem_A = addr_q[`ADDR+1:2];
  assign mem_W = state == ST_MRG | state == WR;
  // halves are aligned, so the byte shift also lands on the right half lane
  assign sh = {addr_q[1:0], 3'b000};
  assign shifted = mem_Q >> sh;
  assign lane_m = size_q == 2'b00 ? `WORD'(8'hFF) << sh : `WORD'(16'hFFFF) << sh;
  assign lane_d = size_q == 2'b00 ? `WORD'(wdata_q[7:0]) << sh : `WORD'(wdata_q[15:0]) << sh;
  assign merged = (mem_Q & ~lane_m) | lane_d;
  assign mem_D = !mem_W ? '0 : state == WR ? wdata_q : merged;
  assign loaded = size_q == 2'b10 ? mem_Q :
                  size_q == 2'b01 ? {{16{sign_q & shifted[15]}}, shifted[15:0]} :
                                    {{24{sign_q & shifted[7]}}, shifted[7:0]};
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept & !bad) state_nx = (req_we & req_size == 2'b10) ? WR : RD;
      RD:      state_nx = we_q ? ST_MRG : LD_CAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= (accept & bad) | state == LD_CAP | state == ST_MRG | state == WR;
      resp_err   <= accept & bad;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == LD_CAP) resp_rdata <= loaded;
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table plus back-to-back and mid-merge reset sequences.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 10
`endif
module tb_dmem_lsu;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [`ADDR+1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] md;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, req_sign = 0;
  logic [1:0] req_size = 0;
  logic [`ADDR+1:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_W;
  logic [31:0] resp_rdata, mem_D, mem_Q;
  logic [`ADDR-1:0] mem_A;
  logic [31:0] mem [0:(1<<`ADDR)-1];
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  always @(posedge clk) begin
    if (mem_W) mem[mem_A] <= mem_D;
    mem_Q <= mem[mem_A];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [1:0] sz, logic sg, logic [`ADDR+1:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic er, int lat, int wr,
                              logic [31:0] md);
    vec_t v;
    v.we = we; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.err = er; v.lat = lat; v.writes = wr; v.md = md;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_sign = v.sign; req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic run_req(input vec_t v, output int lat, output int writes,
                         output logic [31:0] md, output logic [31:0] rd, output logic er);
    @(negedge clk);
    drive(v);
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0; writes = 0; md = 0; rd = 0; er = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_W) begin writes++; md = mem_D; end
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
    end
  endtask

  vec_t tbl[$];
  vec_t bb[4];

  initial begin
    int lat, wr, idx, cyc, pulses;
    logic [31:0] md, rd, held;
    logic er;
    for (int i = 0; i < (1 << `ADDR); i++) mem[i] = 0;
    tbl.push_back(mk(1, 2, 0, 'h40, 32'h11223344, 0, 0, 2, 1, 32'h11223344));
    tbl.push_back(mk(0, 2, 0, 'h40, 0, 32'h11223344, 0, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h42, 32'h000000AB, 0, 0, 3, 1, 32'h11AB3344));
    tbl.push_back(mk(0, 2, 0, 'h40, 0, 32'h11AB3344, 0, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h44, 32'hFFFFFF80, 0, 0, 3, 1, 32'h00000080));
    tbl.push_back(mk(0, 0, 1, 'h44, 0, 32'hFFFFFF80, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h44, 0, 32'h00000080, 0, 3, 0, 0));
    tbl.push_back(mk(1, 1, 0, 'h46, 32'h12348001, 0, 0, 3, 1, 32'h80010080));
    tbl.push_back(mk(0, 1, 1, 'h46, 0, 32'hFFFF8001, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h46, 0, 32'h00008001, 0, 3, 0, 0));
    tbl.push_back(mk(0, 2, 1, 'h44, 0, 32'h80010080, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h43, 0, 32'h00000011, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h42, 0, 32'hFFFFFFAB, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 'h40, 0, 32'h00003344, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h41, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 2, 0, 'h42, 32'hDEADBEEF, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 'h40, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 'h40, 0, 32'h11AB3344, 0, 3, 0, 0));
    bb[0] = mk(1, 2, 0, 'h80, 32'hA5A5A5A5, 0, 0, 2, 1, 0);
    bb[1] = mk(0, 2, 0, 'h80, 0, 32'hA5A5A5A5, 0, 3, 0, 0);
    bb[2] = mk(1, 0, 0, 'h81, 32'h0000003C, 0, 0, 3, 1, 0);
    bb[3] = mk(0, 2, 0, 'h80, 0, 32'hA5A53CA5, 0, 3, 0, 0);

    #12;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_mem_W", mem_W, 0);
    check("rst_mem_D", mem_D, 0);
    check("rst_mem_A", 32'(mem_A), 0);
    @(negedge clk) rst_n = 1;

    held = 0;
    foreach (tbl[i]) begin
      run_req(tbl[i], lat, wr, md, rd, er);
      check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("v%0d_err", i), er, tbl[i].err);
      check($sformatf("v%0d_writes", i), wr, tbl[i].writes);
      if (tbl[i].writes > 0) check($sformatf("v%0d_mem_D", i), md, tbl[i].md);
      if (!tbl[i].we && !tbl[i].err) held = tbl[i].rdata;
      check($sformatf("v%0d_rdata", i), rd, held);
    end

    @(negedge clk);
    drive(bb[0]);
    req_valid = 1;
    idx = 0; cyc = 0;
    for (int g = 0; g < 40 && idx < 4; g++) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        check($sformatf("bb%0d_lat", idx), cyc, bb[idx].lat);
        check($sformatf("bb%0d_ready", idx), req_ready, 1);
        check($sformatf("bb%0d_err", idx), resp_err, 0);
        if (!bb[idx].we) check($sformatf("bb%0d_rdata", idx), resp_rdata, bb[idx].rdata);
        idx++; cyc = 0;
        if (idx < 4) drive(bb[idx]);
        else req_valid = 0;
      end
    end
    req_valid = 0;
    check("bb_responses", idx, 4);

    @(negedge clk);
    drive(mk(1, 0, 0, 'h40, 32'h00000077, 0, 0, 3, 1, 0));
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("mrg_mem_W_before", mem_W, 1);
    #1 rst_n = 0;
    #1;
    check("mrg_mem_W_reset", mem_W, 0);
    check("mrg_mem_D_reset", mem_D, 0);
    check("mrg_resp_valid_reset", resp_valid, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    check("mrg_ready_after", req_ready, 1);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("mrg_no_resp", pulses, 0);
    check("mrg_mem_unchanged", mem['h10], 32'h11AB3344);
    run_req(mk(0, 2, 0, 'h40, 0, 0, 0, 3, 0, 0), lat, wr, md, rd, er);
    check("mrg_reload_lat", lat, 3);
    check("mrg_reload_rdata", rd, 32'h11AB3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the CPU memory stage and the word-wide, single-port, synchronous data memory (`WORD`-bit words, `ADDR`-bit word address, 1-cycle read latency, read and write mutually exclusive per cycle). It accepts byte-addressed load/store requests of byte, halfword or word size. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write, because the memory has no byte enables.

## Interface
Widths come from `params.vh`: `WORD` = 32, `ADDR` = word-address width.

Parameters:
- none. All widths come from the `WORD` and `ADDR` macros.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Unit idle and able to accept; equals (state == IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  Loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  `ADDR`+2  Byte address.
- req_wdata  in  32  Store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  One-cycle completion pulse, for every accepted request.
- resp_err  out  1  Qualified by resp_valid; misaligned or illegal request.
- resp_rdata  out  32  Load result, qualified by resp_valid.
- mem_A  out  `ADDR`  Word address to memory; equals latched byte address [`ADDR`+1:2].
- mem_W  out  1  Memory write enable.
- mem_D  out  32  Memory write data.
- mem_Q  in  32  Memory read data, valid the cycle after a read is presented.

## Operation
- Acceptance: a request is accepted on a rising edge where req_valid & req_ready. At that edge all request fields are latched.
- Legality check at acceptance:
  - size 11 is illegal.
  - half with addr[0] = 1 is misaligned.
  - word with addr[1:0] != 0 is misaligned.
  - An illegal or misaligned request produces resp_valid = 1 and resp_err = 1 in the next cycle, with no memory access (mem_W never asserted). State stays IDLE.
- Byte lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- States:
  - IDLE: mem_W = 0.
    - Legal load → RD.
    - Word store → WR.
    - Sub-word store → RD.
  - RD: mem_A driven, mem_W = 0 (read issued).
    - Load → LD_CAP.
    - Store → ST_MRG.
  - LD_CAP: mem_Q valid. At the next edge: resp_rdata <= extended lane of mem_Q, resp_valid <= 1, state → IDLE.
  - ST_MRG: mem_W = 1; mem_D = mem_Q with the addressed lane replaced by req_wdata[7:0] or [15:0] (combinational from mem_Q). At the next edge: resp_valid <= 1, state → IDLE.
  - WR: mem_W = 1, mem_D = req_wdata. At the next edge: resp_valid <= 1, state → IDLE.
- mem_W is 1 only in WR and ST_MRG. mem_D = 0 whenever mem_W = 0.
- Extension:
  - Word loads ignore req_sign.
  - Byte sign-extension replicates bit 7; half sign-extension replicates bit 15.
- resp_rdata updates only on successful loads. It holds its value on stores and errors.
- resp_err = 0 on every successful response.

## Timing
- Reset values (while rst_n low): state IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, latched request = 0, mem_W = 0, mem_D = 0. The memory contents are not reset.
- Latency from the acceptance edge E0 to the resp_valid cycle:
  - Error: 1 cycle.
  - Word store: 2 cycles (WR, then response).
  - Load and sub-word store: 3 cycles (RD, LD_CAP or ST_MRG, then response).
- Throughput:
  - req_ready returns high in the same cycle as resp_valid, so a new request can be accepted at the edge ending the response cycle.
  - Requests are never overlapped.
- Back-to-back: a load following a store to the same word returns the stored data.
- Reset mid-operation:
  - Asynchronous entry to IDLE.
  - mem_W drops immediately, so a pending merge write is abandoned.
  - No resp_valid is produced for the aborted request.
- req_valid while busy is ignored (req_ready = 0). The requester must hold it.

## Test plan
- Word store 0x11223344 to byte address 0x40, then word load from 0x40 → mem_W high for exactly 1 cycle; load resp_rdata = 0x11223344 on the 3rd cycle after acceptance, resp_err = 0.
- Byte store 0xAB to 0x42 over 0x11223344 → single mem_W cycle with mem_D = 0x11AB3344; word reload gives 0x11AB3344.
- Byte 0x80 at lane 0: signed load → 0xFFFFFF80; unsigned load → 0x00000080. Half 0x8001 at 0x46 (h = 1): signed load → 0xFFFF8001.
- Half load at 0x41, word store at 0x42, size 11 → each gives resp_valid with resp_err = 1 one cycle after acceptance; mem_W stays 0; memory unchanged.
- req_valid held continuously with alternating store/load → each new request accepted in the cycle resp_valid is high; no bubble beyond the specified latency; no dropped or duplicated responses.
- rst_n asserted during ST_MRG of a byte store → mem_W low immediately, no resp_valid, memory word unchanged, req_ready = 1 after reset release.
